// File: rtl/mandelbrot_iter_if.sv
// Handshake bundle between a point source/result sink and mandelbrot_iter.
interface mandelbrot_iter_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] c_r;
  logic signed [WIDTH-1:0] c_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_WIDTH-1:0]    out_count;
  logic                    out_escaped;

  modport master (
    output in_valid, c_r, c_i, out_ready,
    input  in_ready, out_valid, out_count, out_escaped
  );

  modport slave (
    input  in_valid, c_r, c_i, out_ready,
    output in_ready, out_valid, out_count, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter.sv
// Mandelbrot iteration controller and its combinational z^2 + c step stage.
// Fixed point is signed Q4.(WIDTH-4).

// One combinational step: out = in_z^2 + in_c, truncated to WIDTH bits.
module mandelbrot #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] in_cr,
  input  logic signed [WIDTH-1:0] in_ci,
  input  logic signed [WIDTH-1:0] in_zr,
  input  logic signed [WIDTH-1:0] in_zi,
  output logic signed [WIDTH-1:0] out_zr,
  output logic signed [WIDTH-1:0] out_zi
);
  localparam int FRAC = WIDTH - 4;

  logic signed [2*WIDTH-1:0] zr_sq;
  logic signed [2*WIDTH-1:0] zi_sq;
  logic signed [2*WIDTH-1:0] zr_zi;

  // Full-precision products, rescale back to Q4.FRAC, then add c
  always_comb begin
    zr_sq  = in_zr * in_zr;
    zi_sq  = in_zi * in_zi;
    zr_zi  = in_zr * in_zi;
    out_zr = WIDTH'(({zr_sq[2*WIDTH-1], zr_sq} - {zi_sq[2*WIDTH-1], zi_sq}) >>> FRAC) + in_cr;
    // 2*zr*zi folded into the shift: one fewer fractional bit to drop
    out_zi = WIDTH'(zr_zi >>> (FRAC - 1)) + in_ci;
  end
endmodule

module mandelbrot_iter #(
  parameter int WIDTH     = 8,
  parameter int MAX_ITER  = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mandelbrot_iter_if.slave   bus
);
  localparam int FRAC = WIDTH - 4;
  localparam logic [2*WIDTH:0]     ESC_LIM = (2*WIDTH+1)'(4) << (2*FRAC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_ITER);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] cr, ci, zr, zi;
  logic signed [WIDTH-1:0] step_zr, step_zi;
  logic [CNT_WIDTH-1:0]    count;
  logic                    out_valid_q;
  logic [CNT_WIDTH-1:0]    out_count_q;
  logic                    out_escaped_q;
  logic [2*WIDTH-1:0]      zr_sq, zi_sq;
  logic [2*WIDTH:0]        mag;
  logic                    escaped;

  mandelbrot #(.WIDTH(WIDTH)) u_step (
    .in_cr  (cr),
    .in_ci  (ci),
    .in_zr  (zr),
    .in_zi  (zi),
    .out_zr (step_zr),
    .out_zi (step_zi)
  );

  // Escape test on the current z: |z|^2 strictly above 4.0, no truncation
  always_comb begin
    zr_sq   = zr * zr;
    zi_sq   = zi * zi;
    mag     = {1'b0, zr_sq} + {1'b0, zi_sq};
    escaped = (mag > ESC_LIM);
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cr            <= '0;
      ci            <= '0;
      zr            <= '0;
      zi            <= '0;
      count         <= '0;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      out_escaped_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cr    <= bus.c_r;
            ci    <= bus.c_i;
            zr    <= '0;
            zi    <= '0;
            count <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          if (escaped) begin
            out_valid_q   <= 1'b1;
            out_count_q   <= count;
            out_escaped_q <= 1'b1;
            state         <= S_DONE;
          end else if (count == CNT_MAX) begin
            out_valid_q   <= 1'b1;
            out_count_q   <= CNT_MAX;
            out_escaped_q <= 1'b0;
            state         <= S_DONE;
          end else begin
            zr    <= step_zr;
            zi    <= step_zi;
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready is a state decode, forced low while reset is held
  assign bus.in_ready    = (state == S_IDLE) && !reset;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_count   = out_count_q;
  assign bus.out_escaped = out_escaped_q;
endmodule

// File: tb/tb_mandelbrot_iter.sv
// Scoreboard bench for mandelbrot_iter: driver pushes expected results,
// monitor pops and compares when a result appears.
module tb_mandelbrot_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int cnt;
    int esc;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc = 0;
  int   held_cnt = 0;
  int   held_esc = 0;
  bit   prev_valid = 1'b0;

  mandelbrot_iter_if #(.WIDTH(8), .CNT_WIDTH(4)) bus ();

  mandelbrot_iter #(.WIDTH(8), .MAX_ITER(15), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Must be called on a negedge; returns #1 after the accepting edge
  task automatic send(input int cr, input int ci, input int cnt, input int esc,
                      output int acc);
    bit done = 1'b0;
    acc = -1;
    bus.c_r = 8'(cr);
    bus.c_i = 8'(ci);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.in_ready) begin
        acc = cyc + 1;
        sb.push_back('{cnt: cnt, esc: esc, acc: acc});
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid && bus.in_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: compare each new result, then check it holds while stalled
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        chk("in_ready_in_done", int'(bus.in_ready), 0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_count", int'(bus.out_count), e.cnt);
            chk("out_escaped", int'(bus.out_escaped), e.esc);
            chk("latency", cyc - e.acc, e.cnt + 1);
          end
          held_cnt = int'(bus.out_count);
          held_esc = int'(bus.out_escaped);
        end else begin
          chk("hold_count", int'(bus.out_count), held_cnt);
          chk("hold_escaped", int'(bus.out_escaped), held_esc);
        end
        if (bus.out_ready) xfer_cyc = cyc + 1;
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    int acc;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.c_r = '0;
    bus.c_i = '0;

    // Reset state
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_out_escaped", int'(bus.out_escaped), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rel_in_ready", int'(bus.in_ready), 1);

    // Directed points: {c_r, c_i, count, escaped}
    @(negedge clk); send(0, 0, 15, 0, acc);      wait_idle();
    @(negedge clk); send(16, 0, 3, 1, acc);      wait_idle();
    @(negedge clk); send(32, 0, 2, 1, acc);      wait_idle();
    @(negedge clk); send(0, 16, 15, 0, acc);     wait_idle();
    @(negedge clk); send(-32, 0, 15, 0, acc);    wait_idle();
    @(negedge clk); send(0, 32, 2, 1, acc);      wait_idle();
    @(negedge clk); send(-16, 0, 15, 0, acc);    wait_idle();
    @(negedge clk); send(24, 24, 1, 1, acc);     wait_idle();

    // Backpressure: stall in DONE, pulse in_valid, then release with in_valid high
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(16, 0, 3, 1, acc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) chk("bp_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", int'(bus.out_valid), 1);
      if (i == 4) begin
        bus.c_r = 8'sd0;
        bus.c_i = 8'sd0;
        bus.in_valid = 1'b1;
      end
      if (i == 5) bus.in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.c_r = 8'sd32;
    bus.c_i = 8'sd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    send(32, 0, 2, 1, acc);
    chk("accept_after_xfer", acc - xfer_cyc, 1);
    wait_idle();

    // Reset in the middle of iteration, at count 5
    @(negedge clk);
    send(0, 0, 15, 0, acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_count", int'(bus.out_count), 0);
    chk("mid_rst_out_escaped", int'(bus.out_escaped), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("mid_rel_in_ready", int'(bus.in_ready), 1);
    @(negedge clk); send(16, 0, 3, 1, acc);      wait_idle();
    @(negedge clk); send(0, 0, 15, 0, acc);      wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
